// File: rtl/bumpy_collision_detector_pkg.sv
// ---------------------------------------------------------------------------
// bumpy_collision_pkg
// Shared types and constants for the Bumpy collision detector slice.
//   - Edge bit positions inside the 4-bit hit-edge code {Left,Top,Right,Bottom}
//   - Overlap type indices used for the per-type flag/counter vectors
//   - FSM state type and the saturating hit-counter helper
// Optional feature macro used by this slice: BUMPY_HIT_COUNT_EN
// ---------------------------------------------------------------------------
package bumpy_collision_pkg;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  localparam int OFFSET_W  = 11;
  localparam int HIT_CNT_W = 11;

  // Index of each overlap type inside the 3-bit type vectors
  localparam int TYPE_PLAT  = 2;
  localparam int TYPE_TRANS = 1;
  localparam int TYPE_WALL  = 0;

  typedef logic [3:0] edge_code_t;
  typedef logic [HIT_CNT_W-1:0] hit_cnt_t;

  typedef enum logic {
    SCAN   = 1'b0,
    REPORT = 1'b1
  } coll_state_t;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic hit_cnt_t satInc(input hit_cnt_t cnt);
    return (cnt == {HIT_CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/bumpy_collision_detector_if.sv
// ---------------------------------------------------------------------------
// bumpy_collision_detector_if
// Groups the raster-side drawing requests and the collision results.
//   master : video/raster side, drives the per-pixel requests and consumes
//            the collision results
//   slave  : the collision detector
// Signals:
//   startOfFrame, bumpyDrawingRequest, bumpyOffsetX/Y, platform/
//   transplatform/wallDrawingRequest          (master -> slave)
//   collision_platform/transplatform/wall, HitEdgeCode, collision_any
//   wallHitCount (only with BUMPY_HIT_COUNT_EN) (slave -> master)
// ---------------------------------------------------------------------------
interface bumpy_collision_detector_if;
  import bumpy_collision_pkg::*;

  logic                startOfFrame;
  logic                bumpyDrawingRequest;
  logic [OFFSET_W-1:0] bumpyOffsetX;
  logic [OFFSET_W-1:0] bumpyOffsetY;
  logic                platformDrawingRequest;
  logic                transplatformDrawingRequest;
  logic                wallDrawingRequest;

  logic                collision_platform;
  logic                collision_transplatform;
  logic                collision_wall;
  edge_code_t          HitEdgeCode;
  logic                collision_any;
`ifdef BUMPY_HIT_COUNT_EN
  hit_cnt_t            wallHitCount;
`endif

  modport master (
    output startOfFrame, bumpyDrawingRequest, bumpyOffsetX, bumpyOffsetY,
           platformDrawingRequest, transplatformDrawingRequest, wallDrawingRequest,
    input  collision_platform, collision_transplatform, collision_wall,
`ifdef BUMPY_HIT_COUNT_EN
           wallHitCount,
`endif
           HitEdgeCode, collision_any
  );

  modport slave (
    input  startOfFrame, bumpyDrawingRequest, bumpyOffsetX, bumpyOffsetY,
           platformDrawingRequest, transplatformDrawingRequest, wallDrawingRequest,
    output collision_platform, collision_transplatform, collision_wall,
`ifdef BUMPY_HIT_COUNT_EN
           wallHitCount,
`endif
           HitEdgeCode, collision_any
  );

endinterface

// File: rtl/bumpy_collision_detector_edge_classifier.sv
// ---------------------------------------------------------------------------
// bumpy_edge_classifier
// Purely combinational: tells which edge bands of the Bumpy sprite the
// current pixel offset lies in. A corner pixel sets two bits.
//   offX_i, offY_i : pixel offset inside the sprite
//   edges_o        : {Left, Top, Right, Bottom}
// ---------------------------------------------------------------------------
module bumpy_edge_classifier
  import bumpy_collision_pkg::*;
#(
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int EDGE_DEPTH = 4
) (
  input  logic [OFFSET_W-1:0] offX_i,
  input  logic [OFFSET_W-1:0] offY_i,
  output edge_code_t          edges_o
);

  localparam logic [OFFSET_W-1:0] NEAR_LIMIT   = OFFSET_W'(EDGE_DEPTH);
  localparam logic [OFFSET_W-1:0] RIGHT_LIMIT  = OFFSET_W'(SPRITE_W - EDGE_DEPTH);
  localparam logic [OFFSET_W-1:0] BOTTOM_LIMIT = OFFSET_W'(SPRITE_H - EDGE_DEPTH);

  always_comb begin
    edges_o              = '0;
    edges_o[EDGE_LEFT]   = (offX_i <  NEAR_LIMIT);
    edges_o[EDGE_TOP]    = (offY_i <  NEAR_LIMIT);
    edges_o[EDGE_RIGHT]  = (offX_i >= RIGHT_LIMIT);
    edges_o[EDGE_BOTTOM] = (offY_i >= BOTTOM_LIMIT);
  end

endmodule

// File: rtl/bumpy_collision_detector.sv
// ---------------------------------------------------------------------------
// bumpy_collision_detector
// Watches the per-pixel drawing requests during the raster scan, records
// where Bumpy overlaps a platform, trans-platform or wall, and once per frame
// reports the result of the frame that just ended:
//   - single-cycle collision pulses in the cycle after startOfFrame
//   - a held {Left,Top,Right,Bottom} edge code of wall overlaps
//   - a held collision_any level
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : bumpy_collision_detector_if.slave (requests in, results out)
// Optional feature macro BUMPY_HIT_COUNT_EN: per-type saturating overlap
// counters with a MIN_HIT_PIXELS threshold and a wallHitCount output;
// without it each type uses a sticky flag.
// ---------------------------------------------------------------------------
module bumpy_collision_detector
  import bumpy_collision_pkg::*;
#(
  parameter int SPRITE_W       = 32,
  parameter int SPRITE_H       = 32,
  parameter int EDGE_DEPTH     = 4,
  parameter int MIN_HIT_PIXELS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  bumpy_collision_detector_if.slave bus
);

  coll_state_t state_q, state_d;
  edge_code_t  edgeAcc_q, edgeAcc_d;
  edge_code_t  hitEdge_q, hitEdge_d;
  logic        any_q, any_d;
  logic [2:0]  reportHit_q, reportHit_d;

  logic [2:0]  ovType;
  logic [2:0]  frameHit;
  edge_code_t  pixelEdges;
  edge_code_t  wallEdges;
  logic        sof;

  assign sof = bus.startOfFrame;

  assign ovType[TYPE_PLAT]  = bus.bumpyDrawingRequest & bus.platformDrawingRequest;
  assign ovType[TYPE_TRANS] = bus.bumpyDrawingRequest & bus.transplatformDrawingRequest;
  assign ovType[TYPE_WALL]  = bus.bumpyDrawingRequest & bus.wallDrawingRequest;

  bumpy_edge_classifier #(
    .SPRITE_W   (SPRITE_W),
    .SPRITE_H   (SPRITE_H),
    .EDGE_DEPTH (EDGE_DEPTH)
  ) u_edge_classifier (
    .offX_i  (bus.bumpyOffsetX),
    .offY_i  (bus.bumpyOffsetY),
    .edges_o (pixelEdges)
  );

  // Only wall overlaps contribute to the edge code
  assign wallEdges = ovType[TYPE_WALL] ? pixelEdges : '0;

`ifdef BUMPY_HIT_COUNT_EN
  // Per-type saturating counters; a type counts as hit only once it has
  // collected enough pixels, which filters out single-pixel grazes.
  localparam hit_cnt_t HIT_THRESHOLD = HIT_CNT_W'(MIN_HIT_PIXELS);

  hit_cnt_t [2:0] cnt_q, cnt_d;
  hit_cnt_t       wallCount_q, wallCount_d;

  always_comb begin
    cnt_d       = cnt_q;
    wallCount_d = wallCount_q;
    frameHit    = '0;
    for (int i = 0; i < 3; i++) begin
      frameHit[i] = (cnt_q[i] >= HIT_THRESHOLD);
      if (sof) begin
        cnt_d[i] = HIT_CNT_W'(ovType[i]);
      end else if (ovType[i]) begin
        cnt_d[i] = satInc(cnt_q[i]);
      end
    end
    if (sof) begin
      wallCount_d = cnt_q[TYPE_WALL];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      wallCount_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      wallCount_q <= wallCount_d;
    end
  end

  assign bus.wallHitCount = wallCount_q;
`else
  // Sticky per-type flags: any single overlapping pixel marks the type.
  logic [2:0] sticky_q, sticky_d;

  always_comb begin
    frameHit = sticky_q;
    sticky_d = sof ? ovType : (sticky_q | ovType);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end
`endif

  // Next-state and capture logic. On startOfFrame the finished frame is
  // copied into the report registers and the accumulators restart with the
  // current pixel only, so that pixel belongs to the new frame. A second
  // startOfFrame arriving while in REPORT starts another one-cycle REPORT
  // so the (nearly empty) back-to-back frame still gets its own report.
  always_comb begin
    state_d     = state_q;
    edgeAcc_d   = edgeAcc_q | wallEdges;
    hitEdge_d   = hitEdge_q;
    any_d       = any_q;
    reportHit_d = reportHit_q;

    case (state_q)
      SCAN:    state_d = sof ? REPORT : SCAN;
      REPORT:  state_d = sof ? REPORT : SCAN;
      default: state_d = SCAN;
    endcase

    if (sof) begin
      edgeAcc_d   = wallEdges;
      hitEdge_d   = edgeAcc_q;
      reportHit_d = frameHit;
      any_d       = |frameHit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      edgeAcc_q   <= '0;
      hitEdge_q   <= '0;
      any_q       <= 1'b0;
      reportHit_q <= '0;
    end else begin
      state_q     <= state_d;
      edgeAcc_q   <= edgeAcc_d;
      hitEdge_q   <= hitEdge_d;
      any_q       <= any_d;
      reportHit_q <= reportHit_d;
    end
  end

  // Pulses are gated by the REPORT state so they last exactly one cycle;
  // the edge code and collision_any are held until the next capture.
  assign bus.collision_platform      = (state_q == REPORT) & reportHit_q[TYPE_PLAT];
  assign bus.collision_transplatform = (state_q == REPORT) & reportHit_q[TYPE_TRANS];
  assign bus.collision_wall          = (state_q == REPORT) & reportHit_q[TYPE_WALL];
  assign bus.HitEdgeCode             = hitEdge_q;
  assign bus.collision_any           = any_q;

endmodule

// File: tb/tb_bumpy_collision_detector.sv
// ---------------------------------------------------------------------------
// tb_bumpy_collision_detector
// Self-checking bench for bumpy_collision_detector. A reference model fed by
// the driven pixels pushes the expected report of each frame on every
// startOfFrame; the test tasks pop it in the following REPORT cycle and
// compare. Between reports the pulses must be low and the held outputs
// unchanged. Honours BUMPY_HIT_COUNT_EN.
// ---------------------------------------------------------------------------
module tb_bumpy_collision_detector;
  import bumpy_collision_pkg::*;

  localparam int MIN_HIT = 2;
  localparam int SAT_MAX = 2047;

  typedef struct {
    logic       p;
    logic       t;
    logic       w;
    logic [3:0] edges;
    int         wallCnt;
  } rep_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bumpy_collision_detector_if bus();

  bumpy_collision_detector #(
    .SPRITE_W       (32),
    .SPRITE_H       (32),
    .EDGE_DEPTH     (4),
    .MIN_HIT_PIXELS (MIN_HIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] obs;
  assign obs = {bus.collision_platform, bus.collision_transplatform,
                bus.collision_wall, bus.collision_any, bus.HitEdgeCode};

  rep_t       expQ[$];
  rep_t       e;
  int         checks = 0;
  int         errors = 0;
  int         mCnt[3];
  logic [3:0] mEdge;
  logic [3:0] heldEdge;
  logic       heldAny;

  // Edge bands for a 32x32 sprite with 4-pixel bands: {L,T,R,B}
  function automatic logic [3:0] refEdges(input int x, input int y);
    return {(x < 4), (y < 4), (x >= 28), (y >= 28)};
  endfunction

  function automatic logic typeHit(input int c);
`ifdef BUMPY_HIT_COUNT_EN
    return (c >= MIN_HIT);
`else
    return (c >= 1);
`endif
  endfunction

  // Drive one cycle of raster inputs and advance the reference model
  task automatic tick(input logic sof, input logic b, input int x, input int y,
                      input logic p, input logic t, input logic w);
    logic [2:0] ov;
    bus.startOfFrame                = sof;
    bus.bumpyDrawingRequest         = b;
    bus.bumpyOffsetX                = 11'(x);
    bus.bumpyOffsetY                = 11'(y);
    bus.platformDrawingRequest      = p;
    bus.transplatformDrawingRequest = t;
    bus.wallDrawingRequest          = w;
    @(posedge clk);
    ov = {b & w, b & t, b & p};
    if (reset) begin
      for (int i = 0; i < 3; i++) mCnt[i] = 0;
      mEdge    = '0;
      heldEdge = '0;
      heldAny  = 1'b0;
      expQ.delete();
    end else if (sof) begin
      expQ.push_back('{typeHit(mCnt[0]), typeHit(mCnt[1]), typeHit(mCnt[2]),
                       mEdge, mCnt[2]});
      for (int i = 0; i < 3; i++) mCnt[i] = int'(ov[i]);
      mEdge = ov[2] ? refEdges(x, y) : 4'b0000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        mCnt[i] = mCnt[i] + int'(ov[i]);
        if (mCnt[i] > SAT_MAX) mCnt[i] = SAT_MAX;
      end
      if (ov[2]) mEdge = mEdge | refEdges(x, y);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_init cycle %0d: got %b expected 00000000", i, obs);
      end
    end
    reset = 1'b0;
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 1);
    tick(0, 1, 31, 31, 0, 0, 1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 1, 1, 1);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_midframe cycle %0d: got %b expected 00000000", i, obs);
      end
    end
    reset = 1'b0;
    idle(2);
    tick(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL reset_report: no expected report queued");
    end else begin
      e = expQ.pop_front();
      if (obs !== {e.p, e.t, e.w, e.p | e.t | e.w, e.edges} || obs !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_report: got %b expected 00000000", obs);
      end
      heldEdge = e.edges;
      heldAny  = e.p | e.t | e.w;
    end
  endtask

  task automatic test_platform;
    tick(0, 1, 10, 31, 1, 0, 0);
    idle(3);
    tick(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL platform_report: no expected report queued");
    end else begin
      e = expQ.pop_front();
      if (obs !== {e.p, e.t, e.w, e.p | e.t | e.w, e.edges}) begin
        errors++;
        $display("[TB] FAIL platform_report: got %b expected %b", obs,
                 {e.p, e.t, e.w, e.p | e.t | e.w, e.edges});
      end
      heldEdge = e.edges;
      heldAny  = e.p | e.t | e.w;
    end
    idle(1);
    checks++;
    if (obs !== {3'b000, heldAny, heldEdge}) begin
      errors++;
      $display("[TB] FAIL platform_pulse_width: got %b expected %b", obs, {3'b000, heldAny, heldEdge});
    end
  endtask

  task automatic test_wall_corner;
    tick(0, 1, 0, 0, 0, 0, 1);
    idle(2);
    tick(0, 1, 31, 15, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 0);
    checks++;
    e = expQ.pop_front();
    if (obs !== {e.p, e.t, e.w, e.p | e.t | e.w, e.edges} || (e.w && obs[3:0] !== 4'b1110)) begin
      errors++;
      $display("[TB] FAIL wall_corner_report: got %b expected %b", obs,
               {e.p, e.t, e.w, e.p | e.t | e.w, e.edges});
    end
    heldEdge = e.edges;
    heldAny  = e.p | e.t | e.w;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checks++;
      if (obs !== {3'b000, heldAny, heldEdge}) begin
        errors++;
        $display("[TB] FAIL wall_corner_hold cycle %0d: got %b expected %b", i, obs,
                 {3'b000, heldAny, heldEdge});
      end
    end
    tick(1, 0, 0, 0, 0, 0, 0);
    checks++;
    e = expQ.pop_front();
    if (obs !== {e.p, e.t, e.w, e.p | e.t | e.w, e.edges} || obs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL wall_empty_frame: got %b expected 00000000", obs);
    end
    heldEdge = e.edges;
    heldAny  = e.p | e.t | e.w;
  endtask

  task automatic test_frame_boundary;
    tick(1, 1, 12, 12, 0, 1, 0);
    checks++;
    e = expQ.pop_front();
    if (obs !== {e.p, e.t, e.w, e.p | e.t | e.w, e.edges} || obs[6] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL boundary_first_report: got %b expected %b", obs,
               {e.p, e.t, e.w, e.p | e.t | e.w, e.edges});
    end
    idle(4);
    tick(1, 0, 0, 0, 0, 0, 0);
    checks++;
    e = expQ.pop_front();
    if (obs !== {e.p, e.t, e.w, e.p | e.t | e.w, e.edges}) begin
      errors++;
      $display("[TB] FAIL boundary_next_report: got %b expected %b", obs,
               {e.p, e.t, e.w, e.p | e.t | e.w, e.edges});
    end
    heldEdge = e.edges;
    heldAny  = e.p | e.t | e.w;
  endtask

  task automatic test_all_types;
    tick(0, 1, 5, 5, 1, 0, 0);
    tick(0, 1, 6, 5, 1, 0, 0);
    tick(0, 1, 15, 30, 0, 0, 1);
    tick(0, 1, 16, 30, 0, 0, 1);
    tick(0, 1, 20, 10, 0, 1, 0);
    tick(0, 1, 21, 10, 0, 1, 0);
    tick(0, 0, 22, 10, 1, 1, 1);
    tick(1, 0, 0, 0, 0, 0, 0);
    checks++;
    e = expQ.pop_front();
    if (obs !== {e.p, e.t, e.w, e.p | e.t | e.w, e.edges} || obs !== 8'b11110001) begin
      errors++;
      $display("[TB] FAIL all_types_report: got %b expected %b", obs,
               {e.p, e.t, e.w, e.p | e.t | e.w, e.edges});
    end
    heldEdge = e.edges;
    heldAny  = e.p | e.t | e.w;
    idle(1);
    checks++;
    if (obs !== {3'b000, heldAny, heldEdge}) begin
      errors++;
      $display("[TB] FAIL all_types_pulse_width: got %b expected %b", obs, {3'b000, heldAny, heldEdge});
    end
  endtask

  task automatic test_back_to_back;
    tick(0, 1, 10, 10, 1, 0, 0);
    tick(0, 1, 11, 10, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      // k=0 reports the platform frame, k=1 the frame holding only the
      // start-cycle platform pixel, k=2 a truly empty frame
      tick(1, (k == 0), 12, 10, 1, 0, 0);
      checks++;
      e = expQ.pop_front();
      if (obs !== {e.p, e.t, e.w, e.p | e.t | e.w, e.edges}) begin
        errors++;
        $display("[TB] FAIL back_to_back_report %0d: got %b expected %b", k, obs,
                 {e.p, e.t, e.w, e.p | e.t | e.w, e.edges});
      end
      heldEdge = e.edges;
      heldAny  = e.p | e.t | e.w;
    end
    idle(1);
    checks++;
    if (obs !== {3'b000, heldAny, heldEdge}) begin
      errors++;
      $display("[TB] FAIL back_to_back_after: got %b expected %b", obs, {3'b000, heldAny, heldEdge});
    end
  endtask

`ifdef BUMPY_HIT_COUNT_EN
  task automatic test_hit_count;
    tick(0, 1, 10, 10, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 0);
    checks++;
    e = expQ.pop_front();
    if (obs[5] !== 1'b0 || bus.wallHitCount !== 11'd1 || e.wallCnt != 1) begin
      errors++;
      $display("[TB] FAIL hit_count_graze: got wall=%b count=%0d expected wall=0 count=1",
               obs[5], bus.wallHitCount);
    end
    heldEdge = e.edges;
    heldAny  = e.p | e.t | e.w;
    for (int i = 0; i < 3000; i++) tick(0, 1, 10 + (i % 8), 10, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 0);
    checks++;
    e = expQ.pop_front();
    if (obs[5] !== 1'b1 || bus.wallHitCount !== 11'd2047 || e.wallCnt != SAT_MAX) begin
      errors++;
      $display("[TB] FAIL hit_count_saturate: got wall=%b count=%0d expected wall=1 count=2047",
               obs[5], bus.wallHitCount);
    end
    heldEdge = e.edges;
    heldAny  = e.p | e.t | e.w;
  endtask
`endif

  initial begin
    reset    = 1'b1;
    mEdge    = '0;
    heldEdge = '0;
    heldAny  = 1'b0;
    for (int i = 0; i < 3; i++) mCnt[i] = 0;
    test_reset();
    test_platform();
    test_wall_corner();
    test_frame_boundary();
    test_all_types();
    test_back_to_back();
`ifdef BUMPY_HIT_COUNT_EN
    test_hit_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bumpy_collision_detector.md
Name: bumpy_collision_detector

Overview:
- Producer of the collision flags and hit-edge code that the Bumpy movement logic consumes.
- Watches the per-pixel drawing requests during the VGA raster scan and records where the Bumpy sprite overlaps a platform, a trans-platform or a wall.
- Reports one clean, frame-aligned result per frame: single-cycle collision pulses plus a held 4-bit edge code.

Parameters:
- SPRITE_W, 32, Bumpy sprite width in pixels.
- SPRITE_H, 32, Bumpy sprite height in pixels.
- EDGE_DEPTH, 4, depth in pixels of each edge band used for edge classification.
- MIN_HIT_PIXELS, 2, minimum overlap pixels per frame before a type is reported (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at start of each frame.
- bumpyDrawingRequest  in  1  current pixel is an opaque Bumpy pixel.
- bumpyOffsetX  in  11  pixel X offset inside the Bumpy sprite, range 0..SPRITE_W-1.
- bumpyOffsetY  in  11  pixel Y offset inside the Bumpy sprite, range 0..SPRITE_H-1.
- platformDrawingRequest  in  1  current pixel is a platform pixel.
- transplatformDrawingRequest  in  1  current pixel is a trans-platform pixel.
- wallDrawingRequest  in  1  current pixel is a wall pixel.
- collision_platform  out  1  one-cycle pulse: platform overlap occurred last frame.
- collision_transplatform  out  1  one-cycle pulse: trans-platform overlap occurred last frame.
- collision_wall  out  1  one-cycle pulse: wall overlap occurred last frame.
- HitEdgeCode  out  4  edges hit in wall overlaps, ordered {Left, Top, Right, Bottom}; held between reports.
- collision_any  out  1  level signal: any type reported in the current report; held like HitEdgeCode.

Behaviour:
- Reset: all outputs 0, accumulators 0, FSM in SCAN. reset has priority over every other input on any cycle, including mid-frame; the partial frame is discarded.
- FSM states:
  - SCAN: accumulate overlaps. On startOfFrame, go to REPORT.
  - REPORT: lasts exactly 1 cycle, then returns to SCAN.
- Overlap per cycle: ov_p = bumpyDrawingRequest & platformDrawingRequest; ov_t and ov_w are formed the same way with the trans-platform and wall requests.
- Edge classification of the current offset (combinational):
  - L = offX < EDGE_DEPTH
  - R = offX >= SPRITE_W-EDGE_DEPTH
  - T = offY < EDGE_DEPTH
  - B = offY >= SPRITE_H-EDGE_DEPTH
  - A corner pixel sets two bits.
- Accumulation: on each ov_w cycle, edge_acc |= {L,T,R,B}. Per-type sticky flags are set on their overlap.
- Capture on startOfFrame:
  - Accumulators copy into report registers.
  - Accumulators then reload with the current cycle's contribution only, so a pixel overlapping on the startOfFrame cycle belongs to the new frame.
- Output latency: pulses assert in the REPORT cycle, i.e. 1 cycle after startOfFrame. A pulse never coincides with startOfFrame, which the movement logic gives priority.
- HitEdgeCode and collision_any: update in the REPORT cycle and hold until the next REPORT.
- Frame with no overlaps: its REPORT yields no pulses and HitEdgeCode = 0.
- Overlap without wall: platform or trans-platform overlap does not touch HitEdgeCode.
- Back-to-back startOfFrame on consecutive cycles: the second frame is empty (contains at most the pixel on its own start cycle); each pulse still lasts 1 cycle.
- No overlap before the first startOfFrame after reset: no pulses.

Optional Feature:
- Macro: BUMPY_HIT_COUNT_EN.
- With the macro:
  - Per-type 11-bit saturating overlap counters replace the sticky flags; saturation is at 2047 with no wrap.
  - A type reports only if its count >= MIN_HIT_PIXELS, which suppresses single-pixel grazes.
  - Extra output wallHitCount (out, 11 bits) holds the captured wall count, updated in the REPORT cycle.
- Without the macro: sticky flags (threshold effectively 1), and the wallHitCount port is absent.

Decomposition:
- Package bumpy_collision_pkg:
  - Edge index constants EDGE_LEFT=3, EDGE_TOP=2, EDGE_RIGHT=1, EDGE_BOTTOM=0.
  - typedef edge_code_t (logic [3:0]).
  - enum coll_state_t {SCAN, REPORT}.
  - HIT_CNT_W=11.
- Sub-module bumpy_edge_classifier: purely combinational; maps offsets to {L,T,R,B} using the edge parameters.

Test Plan:
- Reset: assert reset for 3 cycles mid-frame while walls overlap → all outputs 0; the next REPORT shows no pulses.
- Platform overlap: ov_p at offset (10,31) for 1 pixel, then startOfFrame → collision_platform = 1 for exactly 1 cycle, 1 cycle after startOfFrame; HitEdgeCode = 0000.
- Wall corner: ov_w at (0,0) and at (31,15) → HitEdgeCode = 1110 held through the whole next frame; collision_wall pulses once. A following empty frame → HitEdgeCode = 0000.
- Frame boundary: ov_t asserted on the same cycle as startOfFrame → not in this REPORT; reported at the following startOfFrame.
- All types: ov_p, ov_t and ov_w in the same frame → all three pulse in the same cycle; collision_any = 1.
- BUMPY_HIT_COUNT_EN, MIN_HIT_PIXELS=2:
  - 1 wall pixel → no pulse, wallHitCount = 1.
  - 3000 wall pixels → pulse, wallHitCount = 2047.
